// File: rtl/wb_lfsr_master.sv
// Wishbone initiator for the LFSR peripheral: seeds it byte by byte, loads and
// runs it, then reads N single bits and presents them packed on a valid/ready port.
module wb_lfsr_master #(
  parameter int         TIMEOUT   = 15,
  parameter logic [7:0] CTRL_LOAD = 8'h03,
  parameter logic [7:0] CTRL_RUN  = 8'h00,
  parameter logic [2:0] RD_ADDR   = 3'b101
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_seed,
  input  logic [4:0]  i_nbits,
  output logic        o_busy,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_timeout,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_addr,
  output logic [7:0]  o_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_data,
  output logic [2:0]  o_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEED = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] READ = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  // Host handshake: o_word is taken in any cycle where o_word_valid and
  // i_word_ready are both high; o_word and o_word_valid are held until then.
  logic [2:0]    state;
  logic [31:0]   seed_q;
  logic [4:0]    nbits_q;
  logic [4:0]    cnt;
  logic [31:0]   sr;
  logic          wait_ack;
  logic [TW-1:0] timer;
  logic [7:0]    next_byte;
  logic [31:0]   sr_next;

  assign o_state = state;
  assign sr_next = {sr[30:0], i_wb_data};

  always_comb begin
    next_byte = 8'h00;
    case (cnt[1:0])
      2'd0:    next_byte = seed_q[15:8];
      2'd1:    next_byte = seed_q[23:16];
      2'd2:    next_byte = seed_q[31:24];
      default: next_byte = seed_q[7:0];
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      seed_q       <= '0;
      nbits_q      <= '0;
      cnt          <= '0;
      sr           <= '0;
      wait_ack     <= 1'b0;
      timer        <= '0;
      o_busy       <= 1'b0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_timeout    <= 1'b0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_data    <= '0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= SEED;
            seed_q    <= i_seed;
            nbits_q   <= i_nbits;
            cnt       <= '0;
            sr        <= '0;
            timer     <= '0;
            o_busy    <= 1'b1;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= 1'b1;
            o_wb_addr <= 3'd0;
            o_wb_data <= i_seed[7:0];
          end
        end
        SEED, LOAD, RUN, READ: begin
          if (o_wb_stb && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            wait_ack <= 1'b1;
          end
          if (wait_ack && i_wb_ack) begin
            wait_ack <= 1'b0;
            timer    <= '0;
            case (state)
              SEED: begin
                o_wb_stb <= 1'b1;
                o_wb_we  <= 1'b1;
                if (cnt == 5'd3) begin
                  state     <= LOAD;
                  cnt       <= '0;
                  o_wb_addr <= 3'd4;
                  o_wb_data <= CTRL_LOAD;
                end else begin
                  cnt       <= cnt + 5'd1;
                  o_wb_addr <= o_wb_addr + 3'd1;
                  o_wb_data <= next_byte;
                end
              end
              LOAD: begin
                state     <= RUN;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= 1'b1;
                o_wb_addr <= 3'd4;
                o_wb_data <= CTRL_RUN;
              end
              RUN: begin
                state     <= READ;
                cnt       <= '0;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= 1'b0;
                o_wb_addr <= RD_ADDR;
                o_wb_data <= 8'h00;
              end
              default: begin
                sr <= sr_next;
                if (cnt == nbits_q) begin
                  state        <= DONE;
                  o_wb_cyc     <= 1'b0;
                  o_word_valid <= 1'b1;
                  o_word       <= sr_next;
                end else begin
                  cnt      <= cnt + 5'd1;
                  o_wb_stb <= 1'b1;
                end
              end
            endcase
          end else if (timer == TW'(TIMEOUT)) begin
            // No ack in time: drop the bus and return without a word.
            state     <= IDLE;
            wait_ack  <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          if (i_word_ready) begin
            state        <= IDLE;
            o_word_valid <= 1'b0;
            o_busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lfsr_master.sv
// Directed bench for wb_lfsr_master with a scripted Wishbone responder
// (optional stalls, optional dropped ack, queued read bits).
module tb_wb_lfsr_master;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_seed;
  logic [4:0]  i_nbits;
  logic        o_busy;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic        o_timeout;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [7:0]  o_wb_data;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic        i_wb_data;
  logic [2:0]  o_state;

  wb_lfsr_master dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_seed(i_seed),
    .i_nbits(i_nbits), .o_busy(o_busy), .o_word(o_word),
    .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
    .o_timeout(o_timeout), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_state(o_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc_num = 0;
  always @(posedge i_clk) cyc_num <= cyc_num + 1;

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] log_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {15'd0, o_busy, o_word, o_word_valid, o_timeout, o_wb_cyc,
            o_wb_stb, o_wb_we, o_wb_addr, o_wb_data};
  endfunction

  // responder
  bit         rd_q[$];
  bit         pend, pend_bit, stb_prev;
  logic [11:0] cap;
  int         stall_left, stall_cycles, unstable;
  bit         stall_en, drop_en, rise4_seen;
  logic [2:0] stall_addr;
  int         stall_n, rise4_cyc;

  initial begin
    i_wb_ack = 0; i_wb_stall = 0; i_wb_data = 0;
    pend = 0; pend_bit = 0; stb_prev = 0; cap = '0;
    stall_left = 0; stall_cycles = 0; unstable = 0;
    stall_en = 0; drop_en = 0; rise4_seen = 0; stall_addr = 0; stall_n = 0; rise4_cyc = 0;
    forever begin
      @(posedge i_clk); #1;
      if (i_reset) begin
        pend = 0; i_wb_ack = 0; i_wb_stall = 0; stb_prev = 0; stall_left = 0;
      end else begin
        i_wb_ack = pend; i_wb_data = pend_bit; pend = 0; pend_bit = 0;
        i_wb_stall = 0;
        if (o_wb_stb) begin
          if (!stb_prev) begin
            cap = {o_wb_we, o_wb_addr, o_wb_data};
            if (o_wb_addr == 3'd4 && !rise4_seen) begin
              rise4_seen = 1; rise4_cyc = cyc_num;
            end
            if (stall_en && o_wb_addr == stall_addr) begin
              stall_left = stall_n; stall_en = 0;
            end
          end else if ({o_wb_we, o_wb_addr, o_wb_data} != cap) begin
            unstable++;
          end
          if (stall_left > 0) begin
            i_wb_stall = 1; stall_left--; stall_cycles++;
          end else begin
            log_q.push_back({o_wb_we, o_wb_addr, o_wb_data});
            if (drop_en && o_wb_addr == 3'd4) drop_en = 0;
            else begin
              pend = 1;
              if (!o_wb_we) pend_bit = (rd_q.size() > 0) ? rd_q.pop_front() : 1'b0;
            end
          end
        end
        stb_prev = o_wb_stb;
      end
    end
  end

  // driver tasks
  int start_cyc;

  task automatic start_cmd(input logic [31:0] seed, input logic [4:0] nbits);
    i_seed = seed; i_nbits = nbits; i_start = 1; start_cyc = cyc_num;
    @(posedge i_clk); #1;
    i_start = 0;
  endtask

  task automatic wait_valid(output int vc);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (o_word_valid) begin seen = 1; break; end
      @(posedge i_clk); #1;
    end
    check("valid_seen", {63'd0, seen}, 64'd1);
    vc = cyc_num - start_cyc;
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] seed, input logic [4:0] nbits,
                         input logic [31:0] exp_word, input int exp_cyc);
    int vc;
    start_cmd(seed, nbits);
    check({tag, "_busy_c1"}, {63'd0, o_busy}, 64'd1);
    wait_valid(vc);
    check({tag, "_word"}, {32'd0, o_word}, {32'd0, exp_word});
    check({tag, "_vcyc"}, vc, exp_cyc);
    @(posedge i_clk); #1;
    check({tag, "_after_hs"}, {62'd0, o_word_valid, o_busy}, 64'd0);
  endtask

  initial begin
    int vc, d, lsz;
    bit ok;
    i_reset = 1; i_start = 0; i_seed = 0; i_nbits = 0; i_word_ready = 1;
    #1;
    check("reset_outs", outs(), 64'd0);
    check("reset_state", {61'd0, o_state}, 64'd0);
    repeat (3) @(posedge i_clk);
    #1; i_reset = 0;
    @(posedge i_clk); #1;

    // basic sequence and write log
    log_q.delete();
    rd_q = '{1, 0, 1, 1, 0, 0, 1, 0};
    run_cmd("t1", 32'hDEADBEEF, 5'd7, 32'h000000B2, 29);
    exp_q = '{12'h8EF, 12'h9BE, 12'hAAD, 12'hBDE, 12'hC03, 12'hC00};
    for (int i = 0; i < 8; i++) exp_q.push_back(12'h500);
    check("t1_log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("t1_log%0d", i), {52'd0, log_q[i]}, {52'd0, exp_q[i]});

    // 3 stall cycles on the addr-2 write
    rd_q = '{1, 0, 1, 1, 0, 0, 1, 0};
    stall_en = 1; stall_addr = 3'd2; stall_n = 3; stall_cycles = 0; unstable = 0;
    run_cmd("t2", 32'hDEADBEEF, 5'd7, 32'h000000B2, 32);
    check("t2_stalls", stall_cycles, 3);
    check("t2_stable", unstable, 0);

    // dropped ack on first addr-4 write
    drop_en = 1; rise4_seen = 0; ok = 0;
    start_cmd(32'h12345678, 5'd3);
    for (int i = 0; i < 100; i++) begin
      if (o_timeout) begin ok = 1; break; end
      if (o_word_valid) break;
      @(posedge i_clk); #1;
    end
    check("t3_timeout_seen", {63'd0, ok}, 64'd1);
    d = cyc_num - rise4_cyc;
    check("t3_timeout_dist", d, 16);
    check("t3_abort_outs", {59'd0, o_wb_cyc, o_wb_stb, o_busy, o_word_valid, o_timeout}, 64'd1);
    check("t3_abort_state", {61'd0, o_state}, 64'd0);
    ok = 1;
    @(posedge i_clk); #1;
    if (o_timeout) ok = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_word_valid || o_busy || o_wb_cyc) ok = 0;
      @(posedge i_clk); #1;
    end
    check("t3_quiet", {63'd0, ok}, 64'd1);
    rd_q = '{1, 0, 1, 1, 0, 0, 1, 0};
    run_cmd("t3_retry", 32'hDEADBEEF, 5'd7, 32'h000000B2, 29);

    // length boundaries
    rd_q.delete();
    for (int i = 0; i < 32; i++) rd_q.push_back(1);
    run_cmd("t4_n32", 32'hA5A5A5A5, 5'd31, 32'hFFFFFFFF, 77);
    rd_q = '{1};
    run_cmd("t4_n1", 32'h00000001, 5'd0, 32'h00000001, 15);

    // host back-pressure, ignored starts
    i_word_ready = 0;
    rd_q = '{1, 1, 0};
    start_cmd(32'hCAFEF00D, 5'd2);
    wait_valid(vc);
    check("t5_vcyc", vc, 19);
    lsz = log_q.size(); ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (o_word !== 32'h6 || !o_busy || !o_word_valid || o_wb_cyc) ok = 0;
      i_start = (i == 3);
      @(posedge i_clk); #1;
    end
    i_start = 0;
    check("t5_hold", {63'd0, ok}, 64'd1);
    i_word_ready = 1; i_start = 1;
    @(posedge i_clk); #1;
    i_start = 0;
    check("t5_hs", {61'd0, o_word_valid, o_busy, o_wb_cyc}, 64'd0);
    @(posedge i_clk); #1;
    check("t5_no_start", {61'd0, o_busy, o_wb_cyc, o_wb_stb}, 64'd0);
    check("t5_no_txn", log_q.size(), lsz);
    rd_q = '{0, 1};
    run_cmd("t5_new", 32'h0BADCAFE, 5'd1, 32'h00000001, 17);

    // asynchronous reset mid-READ
    rd_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    start_cmd(32'hFFFF0000, 5'd7);
    repeat (16) @(posedge i_clk);
    #1;
    check("t6_in_read", {61'd0, o_state}, 64'd4);
    #2 i_reset = 1;
    #1;
    check("t6_reset_outs", outs(), 64'd0);
    repeat (2) @(posedge i_clk);
    #1; i_reset = 0;
    rd_q = '{0, 1, 1, 0};
    @(posedge i_clk); #1;
    run_cmd("t6_clean", 32'h13579BDF, 5'd3, 32'h00000006, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_lfsr_master.md
# wb_lfsr_master

Wishbone initiator that drives the 8-bit-data LFSR peripheral from the controller side. For each host command it:
- writes a 32-bit seed one byte at a time;
- writes the control register twice, first to load the seed and then to run;
- issues N single-bit reads and packs the returned bits into a word.

The word is presented on a valid/ready handshake. It sits between a host sequencer and the LFSR peripheral's Wishbone port.

## Interface
Parameters:
- TIMEOUT, 15: cycles a transaction may wait for ack (including stall cycles) before the command aborts.
- CTRL_LOAD, 8'h03: control byte written to hold the LFSR in reset and load the seed.
- CTRL_RUN, 8'h00: control byte written to release the LFSR.
- RD_ADDR, 3'b101: address used for read transactions.

Ports:
- i_clk, in, 1: single clock, rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_start, in, 1: command strobe; sampled only in IDLE.
- i_seed, in, 32: seed; latched on the accepted i_start.
- i_nbits, in, 5: read count minus one, so N = i_nbits+1 (1..32); latched on the accepted i_start.
- o_busy, out, 1: high from the accepted start until word handshake or abort.
- o_word, out, 32: packed result.
- o_word_valid, out, 1: result valid.
- i_word_ready, in, 1: host accepts the result.
- o_timeout, out, 1: one-cycle pulse on abort.
- o_wb_cyc, out, 1: Wishbone cycle.
- o_wb_stb, out, 1: Wishbone strobe.
- o_wb_we, out, 1: Wishbone write enable.
- o_wb_addr, out, 3: Wishbone address.
- o_wb_data, out, 8: Wishbone write data.
- i_wb_stall, in, 1: Wishbone stall.
- i_wb_ack, in, 1: Wishbone ack.
- i_wb_data, in, 1: read bit; valid in the ack cycle.

## Operation
- States: IDLE, SEED, LOAD, RUN, READ, DONE.
- IDLE -> SEED on i_start: latch i_seed and N; clear the shift register and the byte/read counters.
- SEED: four writes, addr 0..3, data = seed[8k+7:8k], least significant byte first.
- LOAD: write addr 4, data CTRL_LOAD.
- RUN: write addr 4, data CTRL_RUN.
- READ: N reads at RD_ADDR, o_wb_we=0, o_wb_data=0.
- Bit packing on each read ack: shift register <= {sr[30:0], i_wb_data}. The first bit read ends at bit N-1, the last at bit 0, and bits 31..N are 0.
- One outstanding transaction at a time:
  - o_wb_stb is held, with addr/we/data stable, until a cycle with stb & !i_wb_stall.
  - stb is low from the next cycle onward.
  - The master then waits for i_wb_ack.
  - The next transaction's stb rises the cycle after ack.
- o_wb_cyc stays high continuously from the first seed write until the final read ack, or until abort.
- i_wb_ack is ignored when cyc is low or while stb is still pending.
- DONE: cyc=0, o_word_valid=1, o_word stable.
  - On valid & i_word_ready -> IDLE, valid=0, busy=0 next cycle.
- Timeout: a per-transaction counter clears when stb rises and increments each cycle without ack.
  - If no ack arrives within TIMEOUT cycles of stb rising, the next cycle shows cyc=stb=0, o_timeout=1 for that one cycle, and state IDLE.
  - No word is produced on abort and o_busy drops in the same cycle.
- i_start is ignored whenever the state is not IDLE, including the cycle of the word handshake.
- Reset (asynchronous, any state): every output goes to 0 immediately, including o_wb_addr, o_wb_data and o_word. State returns to IDLE and any in-flight transaction is abandoned.

## Timing
- Zero-stall responder with ack one cycle after stb gives 2 cycles per transaction.
- i_start is sampled at the edge ending cycle 0 and the first stb appears in cycle 1.
- Last read ack occurs in cycle 2*(6+N).
- o_word_valid rises and cyc falls in cycle 2*(6+N)+1.
- Each stall cycle or extra ack-wait cycle adds one cycle to that total.
- o_busy rises in cycle 1.
- Every output is registered; no combinational path runs from Wishbone inputs to Wishbone outputs.

## Test plan
- Seed 0xDEADBEEF, i_nbits=7, zero-stall responder returning read bits 1,0,1,1,0,0,1,0:
  - write sequence is (0,EF), (1,BE), (2,AD), (3,DE), (4,03), (4,00), then 8 reads at addr 5;
  - o_word=0x000000B2 and valid in cycle 29.
- Responder stalls 3 cycles on the addr-2 write: stb, addr and data are held stable throughout, and valid moves to cycle 32.
- Responder never acks the first addr-4 write, TIMEOUT=15:
  - cyc and stb drop and o_timeout pulses 16 cycles after that stb rose;
  - o_word_valid stays 0;
  - the next i_start runs the full sequence normally.
- i_nbits=31 with all-ones reads gives 0xFFFFFFFF valid in cycle 77. i_nbits=0 gives a single read, with o_word=0x00000001 for bit 1 and valid in cycle 15.
- Hold i_word_ready low for 10 cycles after valid, with i_start pulsed in that window:
  - o_word stays stable and busy stays high;
  - the start is ignored;
  - after the handshake, a new start is accepted.
- Assert i_reset mid-READ between clock edges: all outputs are 0 immediately without waiting for a clock edge. After release, a clean command completes with the correct word.
